// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC select encoding and default PC constants
package pc_pkg;
    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_RET,
        NPC_RET_UF,
        NPC_BRANCH,
        NPC_SEQ
    } npc_sel_t;
    localparam int PC_W_DEF     = 32;
    localparam int STEP_DEF     = 1;
    localparam int RESET_PC_DEF = 0;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack
    import pc_pkg::*;
#(
    parameter  int PC_W      = PC_W_DEF,
    parameter  int RAS_DEPTH = 4,
    localparam int PW        = $clog2(RAS_DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top_data,
    output logic [CW-1:0]   count,
    output logic            empty,
    output logic            full
);
    logic [PC_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    assign top_data = mem[PW'(ptr - 1'b1)];
    assign empty    = count == '0;
    assign full     = count == CW'(RAS_DEPTH);
    // entry storage needs no reset; slots above count are never read
    always_ff @(posedge clock) begin
        if (push) mem[ptr] <= push_data;
    end
    // ptr is the next free slot; count saturates so a full push just rotates the ring
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr   <= ptr + 1'b1;
            count <= full ? count : count + 1'b1;
        end else if (pop && !empty) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered next-PC select (hold > return > branch > increment) with a return stack
module pc_sequencer
    import pc_pkg::*;
#(
    parameter  int PC_W      = PC_W_DEF,
    parameter  int STEP      = STEP_DEF,
    parameter  int RESET_PC  = RESET_PC_DEF,
    parameter  int RAS_DEPTH = 4,
    localparam int CW        = $clog2(RAS_DEPTH) + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_pc,
    input  logic            link,
    input  logic            ret,
    output logic [PC_W-1:0] pc,
    output logic [CW-1:0]   ras_count,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow
);
    npc_sel_t        sel;
    logic [PC_W-1:0] pc_inc, next_pc, ras_top;
    logic            push, pop;
    // priority decode; a return beats a simultaneous call, so no push happens then
    always_comb begin
        sel     = stall ? NPC_HOLD
                : ret ? (ras_empty ? NPC_RET_UF : NPC_RET)
                : branch_taken ? NPC_BRANCH : NPC_SEQ;
        pc_inc  = pc + PC_W'(STEP);
        next_pc = sel == NPC_HOLD ? pc
                : sel == NPC_RET ? ras_top
                : sel == NPC_BRANCH ? branch_pc : pc_inc;
        push    = sel == NPC_BRANCH && link;
        pop     = sel == NPC_RET;
    end
    // PC register and one-cycle underflow pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc            <= PC_W'(RESET_PC);
            ras_underflow <= 1'b0;
        end else begin
            pc            <= next_pc;
            ras_underflow <= sel == NPC_RET_UF;
        end
    end
    ras_stack #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with a queued scoreboard for pc_sequencer (PC_W=8, depth 4)
module tb_pc_sequencer;
    typedef struct packed {
        logic [7:0] pc;
        logic [2:0] cnt;
        logic       e;
        logic       f;
        logic       u;
    } exp_t;
    logic       clock, reset, stall, branch_taken, link, ret;
    logic [7:0] branch_pc, pc;
    logic [2:0] ras_count;
    logic       ras_empty, ras_full, ras_underflow;
    exp_t       exp_q [$];
    int         id_q  [$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         step_id = 0;
    pc_sequencer #(.PC_W(8), .STEP(1), .RESET_PC(0), .RAS_DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_pc     (branch_pc),
        .link          (link),
        .ret           (ret),
        .pc            (pc),
        .ras_count     (ras_count),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;
    function automatic exp_t mk(input logic [7:0] p, input int c, input logic u);
        mk = {p, 3'(c), c == 0, c == 4, u};
    endfunction
    task automatic chk(input string name, input int id, input exp_t want);
        exp_t act;
        act = {pc, ras_count, ras_empty, ras_full, ras_underflow};
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s#%0d: got pc=%0d cnt=%0d empty=%b full=%b uf=%b, want pc=%0d cnt=%0d empty=%b full=%b uf=%b",
                      name, id, act.pc, act.cnt, act.e, act.f, act.u, want.pc, want.cnt, want.e, want.f, want.u);
    endtask
    task automatic step(input logic s, input logic bt, input logic lk, input logic rt,
                        input logic [7:0] bpc, input logic [7:0] epc, input int ecnt, input logic eu);
        stall = s; branch_taken = bt; link = lk; ret = rt; branch_pc = bpc;
        exp_q.push_back(mk(epc, ecnt, eu));
        id_q.push_back(step_id++);
        @(negedge clock);
    endtask
    always @(posedge clock) begin
        #1;
        if (exp_q.size() != 0) chk("step", id_q.pop_front(), exp_q.pop_front());
    end
    initial begin
        reset = 1'b0; stall = 0; branch_taken = 0; link = 0; ret = 0; branch_pc = '0;
        #2 reset = 1'b1;
        #1 chk("reset", 0, mk(8'd0, 0, 1'b0));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 0, 8'(i), 0, 0);
        step(1, 1, 0, 0, 40, 5, 0, 0);
        step(1, 1, 0, 0, 40, 5, 0, 0);
        step(0, 1, 0, 0, 40, 40, 0, 0);
        step(0, 1, 0, 0, 10, 10, 0, 0);
        step(0, 1, 1, 0, 100, 100, 1, 0);
        step(0, 0, 0, 1, 0, 11, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 20, 20, 1, 0);
        step(0, 1, 1, 0, 40, 40, 2, 0);
        step(0, 1, 1, 0, 60, 60, 3, 0);
        step(0, 1, 1, 0, 80, 80, 4, 0);
        step(0, 1, 1, 0, 200, 200, 4, 0);
        step(0, 0, 0, 1, 0, 81, 3, 0);
        step(0, 0, 0, 1, 0, 61, 2, 0);
        step(0, 0, 0, 1, 0, 41, 1, 0);
        step(0, 0, 0, 1, 0, 21, 0, 0);
        step(0, 0, 0, 1, 0, 22, 0, 1);
        step(0, 0, 0, 0, 0, 23, 0, 0);
        step(0, 1, 0, 0, 6, 6, 0, 0);
        step(0, 1, 1, 0, 50, 50, 1, 0);
        step(0, 1, 1, 1, 90, 7, 0, 0);
        step(0, 0, 0, 0, 0, 8, 0, 0);
        step(0, 1, 0, 0, 254, 254, 0, 0);
        step(0, 0, 0, 0, 0, 255, 0, 0);
        step(0, 1, 1, 0, 30, 30, 1, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 10, 10, 1, 0);
        step(0, 1, 1, 0, 20, 20, 2, 0);
        step(0, 1, 1, 0, 30, 30, 3, 0);
        stall = 0; branch_taken = 0; link = 0; ret = 0;
        #2 reset = 1'b1;
        #1 chk("async_reset", 0, mk(8'd0, 0, 1'b0));
        @(negedge clock);
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 2, 0, 1);
        step(0, 0, 0, 0, 0, 3, 0, 0);
        @(negedge clock);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
